// File: rtl/log_pkg.sv
// log_pkg: state encoding, log-source codes and RAM defaults
// shared by the capture sequencer and its read streamer.
package log_pkg;

    // Default logging RAM geometry
    localparam int RAM_WIDTH_DEF = 32;
    localparam int RAM_DEPTH_DEF = 32768;

    // Log-source select codes driven to the RAM controller mux
    localparam logic [2:0] SEL_NONE   = 3'd0;
    localparam logic [2:0] SEL_EQ_IN  = 3'd1;
    localparam logic [2:0] SEL_EQ_OUT = 3'd2;
    localparam logic [2:0] SEL_TAPS   = 3'd3;

    // Sequencer states; the RD_* states live in the read streamer
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ARM      = 3'd1,
        ST_CAPTURE  = 3'd2,
        ST_RD_ISSUE = 3'd3,
        ST_RD_WAIT  = 3'd4,
        ST_RD_OUT   = 3'd5
    } state_t;

    // True for any state that keeps the RAM read port enabled
    function automatic logic is_rd_state(input state_t s);
        return (s == ST_RD_ISSUE) ||
               (s == ST_RD_WAIT)  ||
               (s == ST_RD_OUT);
    endfunction

endpackage

// File: rtl/log_read_streamer.sv
// log_read_streamer: walks a RAM address range one word at a time,
// absorbs the read latency and presents each word on valid/ready.
module log_read_streamer
    import log_pkg::*;
#(
    parameter int RAM_WIDTH  = RAM_WIDTH_DEF,
    parameter int RAM_DEPTH  = RAM_DEPTH_DEF,
    parameter int RD_LATENCY = 1,
    parameter int ADDR_W     = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_abort,
    input  logic [ADDR_W-1:0]    i_rd_start,
    input  logic [ADDR_W:0]      i_rd_len,
    input  logic [RAM_WIDTH-1:0] i_ram_data,
    input  logic                 i_ready,
    output logic                 o_en_read,
    output logic [ADDR_W-1:0]    o_read_adrs,
    output logic [RAM_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_busy_next,
    output logic                 o_fin,
    output state_t               o_state
);

    localparam int LAT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(RD_LATENCY - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] adrs_q;
    logic [ADDR_W:0]   remain_q;
    logic [LAT_W-1:0]  lat_q;
    logic              xfer;
    logic              last;
    logic              aborting;

    assign aborting    = i_abort && (state_q != ST_IDLE);
    assign xfer        = (state_q == ST_RD_OUT) && o_valid && i_ready;
    assign last        = (remain_q == LEN_ONE);
    assign o_fin       = xfer && last && !aborting;
    assign o_busy_next = (state_d != ST_IDLE);
    assign o_read_adrs = adrs_q;
    assign o_state     = state_q;

    // State register
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: abort overrides every read-side transition
    always_comb begin
        state_d = state_q;
        if (aborting) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (i_start) state_d = ST_RD_ISSUE;
                end
                ST_RD_ISSUE: state_d = ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (lat_q == '0) state_d = ST_RD_OUT;
                end
                ST_RD_OUT: begin
                    if (xfer) state_d = last ? ST_IDLE : ST_RD_ISSUE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Address/length/latency counters and registered outputs
    always_ff @(posedge clk) begin
        if (i_reset) begin
            adrs_q    <= '0;
            remain_q  <= '0;
            lat_q     <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_en_read <= 1'b0;
        end else begin
            o_en_read <= is_rd_state(state_d);
            o_valid   <= (state_d == ST_RD_OUT);

            if ((state_q == ST_IDLE) && i_start) begin
                adrs_q   <= i_rd_start;
                remain_q <= i_rd_len;
            end else if (xfer && !aborting) begin
                adrs_q   <= (adrs_q == ADDR_LAST) ? '0 : adrs_q + 1'b1;
                remain_q <= remain_q - 1'b1;
            end

            if (state_q == ST_RD_ISSUE) begin
                lat_q <= LAT_LOAD;
            end else if ((state_q == ST_RD_WAIT) && (lat_q != '0)) begin
                lat_q <= lat_q - 1'b1;
            end

            if ((state_q == ST_RD_WAIT) && (state_d == ST_RD_OUT)) begin
                o_data <= i_ram_data;
            end
        end
    end

endmodule

// File: rtl/log_capture_sequencer.sv
// log_capture_sequencer: drives the logging RAM controller through
// a timed capture or a streamed readout, with abort at any point.
module log_capture_sequencer
    import log_pkg::*;
#(
    parameter int RAM_WIDTH   = RAM_WIDTH_DEF,
    parameter int RAM_DEPTH   = RAM_DEPTH_DEF,
    parameter int RD_LATENCY  = 1,
    parameter int CAPT_CYCLES = 65536,
    localparam int ADDR_W     = $clog2(RAM_DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_capture,
    input  logic                 i_cmd_read,
    input  logic                 i_cmd_abort,
    input  logic [2:0]           i_sel,
    input  logic [ADDR_W-1:0]    i_rd_start,
    input  logic [ADDR_W:0]      i_rd_len,
    input  logic [RAM_WIDTH-1:0] i_ram_data,
    input  logic                 i_ready,
    output logic [2:0]           o_data_sel_for_log,
    output logic                 o_en_write,
    output logic                 o_en_read,
    output logic [ADDR_W-1:0]    o_read_adrs,
    output logic [RAM_WIDTH-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int TMR_W = $clog2(CAPT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(CAPT_CYCLES - 1);

    state_t           ctl_q;
    state_t           ctl_d;
    state_t           rd_state;
    logic [TMR_W-1:0] tmr_q;
    logic             idle;
    logic             cap_go;
    logic             rd_go;
    logic             zero_go;
    logic             abort;
    logic             cap_fin;
    logic             rd_fin;
    logic             rd_busy_next;
    logic             en_write_d;
    logic             done_d;
    logic             busy_d;
    logic [2:0]       sel_d;

    // Commands are only accepted when both halves are idle;
    // capture wins over a read issued in the same cycle.
    assign idle    = (ctl_q == ST_IDLE) && (rd_state == ST_IDLE);
    assign cap_go  = idle && i_cmd_capture;
    assign rd_go   = idle && i_cmd_read && !i_cmd_capture &&
                     (i_rd_len != '0);
    assign zero_go = idle && i_cmd_read && !i_cmd_capture &&
                     (i_rd_len == '0);
    assign abort   = i_cmd_abort && !idle;
    assign cap_fin = (ctl_q == ST_CAPTURE) && (tmr_q == TMR_LAST) &&
                     !abort;

    log_read_streamer #(
        .RAM_WIDTH  (RAM_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .RD_LATENCY (RD_LATENCY),
        .ADDR_W     (ADDR_W)
    ) u_streamer (
        .clk         (clk),
        .i_reset     (i_reset),
        .i_start     (rd_go),
        .i_abort     (i_cmd_abort),
        .i_rd_start  (i_rd_start),
        .i_rd_len    (i_rd_len),
        .i_ram_data  (i_ram_data),
        .i_ready     (i_ready),
        .o_en_read   (o_en_read),
        .o_read_adrs (o_read_adrs),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_busy_next (rd_busy_next),
        .o_fin       (rd_fin),
        .o_state     (rd_state)
    );

    // State, capture timer and registered control outputs
    always_ff @(posedge clk) begin
        if (i_reset) begin
            ctl_q              <= ST_IDLE;
            tmr_q              <= '0;
            o_data_sel_for_log <= SEL_NONE;
            o_en_write         <= 1'b0;
            o_busy             <= 1'b0;
            o_done             <= 1'b0;
        end else begin
            ctl_q              <= ctl_d;
            o_data_sel_for_log <= sel_d;
            o_en_write         <= en_write_d;
            o_busy             <= busy_d;
            o_done             <= done_d;
            if (ctl_q == ST_ARM) begin
                tmr_q <= '0;
            end else if (ctl_q == ST_CAPTURE) begin
                tmr_q <= tmr_q + 1'b1;
            end
        end
    end

    // Next-state for the arm/capture half
    always_comb begin
        ctl_d = ctl_q;
        if (abort) begin
            ctl_d = ST_IDLE;
        end else begin
            unique case (ctl_q)
                ST_IDLE: begin
                    if (cap_go) ctl_d = ST_ARM;
                end
                ST_ARM: ctl_d = ST_CAPTURE;
                ST_CAPTURE: begin
                    if (tmr_q == TMR_LAST) ctl_d = ST_IDLE;
                end
                default: ctl_d = ST_IDLE;
            endcase
        end
    end

    // Next values of the control outputs; select holds after capture
    always_comb begin
        en_write_d = (ctl_d == ST_ARM);
        done_d     = cap_fin || rd_fin || zero_go;
        busy_d     = (ctl_d != ST_IDLE) || rd_busy_next;
        sel_d      = cap_go ? i_sel : o_data_sel_for_log;
    end

endmodule

// File: doc/log_capture_sequencer.md
Name: log_capture_sequencer

Overview:
- Sequences the logging block RAM controller through capture and readout.
- Capture: selects the log source, pulses the write-enable and waits out a fixed capture window.
- Readout: issues RAM reads over a programmed address range, absorbs the RAM read latency and streams 32-bit words to a downstream consumer through a valid/ready handshake.
- Sits between the host command interface (e.g. UART/VIO front end) and the logging RAM controller.

Parameters:
- RAM_WIDTH, 32, RAM data word width.
- RAM_DEPTH, 32768, RAM depth; ADDR_W = $clog2(RAM_DEPTH).
- RD_LATENCY, 1, RAM read latency in clocks (1 = LOW_LATENCY, 2 = HIGH_PERFORMANCE).
- CAPT_CYCLES, 65536, capture window length in clocks after the write pulse.

Ports:
- clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_cmd_capture  in  1  one-clock pulse: start capture
- i_cmd_read  in  1  one-clock pulse: start readout
- i_cmd_abort  in  1  one-clock pulse: abort any operation
- i_sel  in  3  log source selection, latched at capture start
- i_rd_start  in  ADDR_W  first read address, latched at readout start
- i_rd_len  in  ADDR_W+1  number of words to read (0 = none)
- i_ram_data  in  RAM_WIDTH  RAM read data
- i_ready  in  1  downstream accepts a word
- o_data_sel_for_log  out  3  source select to the RAM controller
- o_en_write  out  1  write-arm pulse to the RAM controller
- o_en_read  out  1  read enable; held high for the whole readout
- o_read_adrs  out  ADDR_W  RAM read address
- o_data  out  RAM_WIDTH  output word
- o_valid  out  1  o_data valid
- o_busy  out  1  state != IDLE
- o_done  out  1  one-clock pulse on normal completion of capture or readout

Behaviour:
- Reset (synchronous, i_reset high at a clk edge):
  - State goes to IDLE.
  - All outputs go to 0, including o_data_sel_for_log.
  - Reset mid-operation abandons that operation with no o_done.
- Registered outputs: all outputs are registered.
- States: IDLE, ARM, CAPTURE, RD_ISSUE, RD_WAIT, RD_OUT.
- IDLE:
  - i_cmd_capture: latch i_sel into o_data_sel_for_log, go to ARM.
  - i_cmd_read with i_rd_len != 0: latch start address and length, go to RD_ISSUE.
  - i_cmd_read with i_rd_len == 0: pulse o_done the next cycle and stay in IDLE.
  - Simultaneous capture and read commands: capture wins; the read command is dropped.
- ARM:
  - o_en_write = 1 for exactly one cycle.
  - Clear the capture timer, go to CAPTURE.
- CAPTURE:
  - Timer counts 0..CAPT_CYCLES-1.
  - At terminal count: pulse o_done, go to IDLE.
  - o_data_sel_for_log holds its value in IDLE afterwards, so the RAM controller keeps a stable mux.
- Readout path:
  - o_en_read = 1 in RD_ISSUE, RD_WAIT and RD_OUT.
  - RD_ISSUE: drive o_read_adrs = current address, load the latency counter, go to RD_WAIT.
  - RD_WAIT: wait RD_LATENCY cycles, then register i_ram_data into o_data, set o_valid = 1, go to RD_OUT.
  - RD_OUT: hold o_data and o_valid stable until i_ready = 1.
  - Word transfer happens on the cycle where o_valid && i_ready.
  - On transfer: address increments, wrapping RAM_DEPTH-1 → 0; remaining count decrements.
  - After transfer: if the remaining count reaches 0, clear o_valid, pulse o_done and go to IDLE; otherwise clear o_valid and go to RD_ISSUE.
- Throughput: one word per RD_LATENCY+2 cycles with i_ready held high. No read-ahead.
- i_cmd_abort:
  - Honoured in any non-IDLE state and takes priority over every other transition.
  - Next state IDLE, o_valid = 0, o_en_read = 0, no o_done.
  - In IDLE it is ignored.
- Command pulses other than abort are ignored while busy.
- i_rd_len = RAM_DEPTH reads the whole RAM once, wrapping from the start address.

Decomposition:
- Shared package log_pkg:
  - state encoding.
  - log-source select codes: SEL_NONE = 0, SEL_EQ_IN = 1, SEL_EQ_OUT = 2, SEL_TAPS = 3.
  - default RAM_WIDTH and RAM_DEPTH.
- One sub-module is natural: log_read_streamer, containing RD_ISSUE, RD_WAIT, RD_OUT, the address/length counters and the output register. The top FSM handles arm, capture and abort.

Test Plan:
- Reset then capture with i_sel = 3'b010, CAPT_CYCLES = 16 → o_en_write high exactly one cycle after ARM; o_done 16 cycles later; o_data_sel_for_log stays 2 afterwards.
- Readout start = 0x0004, len = 3, RD_LATENCY = 1, RAM modelled as data = addr, i_ready = 1 → outputs 0x4, 0x5, 0x6 at 3-cycle spacing, then o_done and o_en_read = 0.
- Wrap: start = 0x7FFE, len = 4 → o_read_adrs sequence 0x7FFE, 0x7FFF, 0x0000, 0x0001.
- Backpressure: i_ready low for 10 cycles on word 2 → o_data and o_valid stable throughout; no address advance; word delivered once i_ready rises.
- Abort during RD_OUT, and separately during CAPTURE → next cycle IDLE, o_valid = 0, o_busy = 0, no o_done.
- i_reset mid-readout, then i_rd_len = 0 command → all outputs 0 after reset; the zero-length read gives an o_done pulse with no o_en_read.
